seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
Parametrised, time-multiplexed hex display driver for common-anode 7-segment banks of DIGITS digits.
- Internal hex-to-segment decode feeds a rotating digit scan with anode-off guard intervals against ghosting.
- Displayed value is double-buffered and only switches at frame boundaries, so there is no tearing.
- Adds leading-zero blanking and per-digit enable/decimal point.
- Sits between CPU status/debug registers and the board's CA/DP/AN pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
DIV, 100000, clock cycles per digit slot (>= 2)
GUARD, 16, blank cycles at start of each slot (0 <= GUARD < DIV)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
load  in  1  one-cycle strobe; capture value/dp_in
value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost
dp_in  in  DIGITS  decimal point request per digit, 1 = lit; captured with value
digit_en  in  DIGITS  live per-digit enable; 0 = digit dark
lz_blank  in  1  live leading-zero blanking enable
CA  out  7  segments a..g as CA[6]..CA[0], active-low
DP  out  1  decimal point, active-low
AN  out  DIGITS  digit anodes, active-low
frame_start  out  1  one-cycle pulse at start of each scan frame

Behaviour:
- Single clock domain.
  - Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - CA=7'b1111111, DP=1, AN=all 1s, frame_start=0.
  - Slot counter cnt=0, digit index idx=0.
  - Active buffer = all zero nibbles and dp all 0.
  - Pending buffer is invalid.
  - Reset mid-operation discards any pending load.
- Scan counters:
  - cnt counts 0..DIV-1.
  - At cnt=DIV-1, cnt wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
  - A frame is DIGITS*DIV cycles.
- Buffering and frame boundary:
  - load=1 writes value/dp_in into the pending buffer and marks it valid.
  - A later load before commit overwrites the pending buffer.
  - Frame boundary = cycle where cnt=DIV-1 and idx=DIGITS-1.
  - At the frame boundary, the active buffer takes load ? inputs : pending if load or pending is valid; pending is then cleared.
  - So load coincident with the boundary commits immediately.
  - frame_start=1 in the following cycle (cnt=0, idx=0), otherwise 0.
  - First frame_start after reset release is at cycle DIGITS*DIV.
- Lighting rule, evaluated combinationally on the current cnt/idx:
  - Digit idx is lit iff cnt >= GUARD and digit_en[idx]=1 and the digit is not leading-zero-blanked.
  - Leading-zero blanked iff lz_blank=1, idx != 0, and active nibbles idx..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
- Outputs are all registered: one-cycle latency from the cnt/idx state to the pins.
  - Lit: AN = one-hot-low at idx, CA = decode(active nibble idx), DP = ~active_dp[idx].
  - Not lit: AN all 1s, CA=7'h7F, DP=1.
- Decode, CA[6:0] per nibble 0..F:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111
  - 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000
- At most one AN bit low in any cycle.
- digit_en and lz_blank are live: they are not buffered and take effect with the one-cycle output latency.
- DIGITS=1: idx is constant 0 and every slot end is a frame boundary.

Optional Feature:
Macro SEVSEG_DIM_EN.
- Defined:
  - Adds input port brightness [3:0].
  - A free-running 4-bit phase counter is added (reset 0, +1 per cycle, wraps).
  - Lighting rule additionally requires phase < brightness.
  - brightness=0 gives a dark display; 15 gives a 15/16 duty cycle.
  - brightness is live.
- Undefined: the port and phase counter are absent, and lit digits are driven for the full non-guard part of the slot.

Test Plan:
All scenarios use DIGITS=4, DIV=8, GUARD=2.
1. reset held 20 cycles with load toggling -> AN=4'b1111, CA=7'h7F, DP=1, frame_start=0 throughout; after release, digits show 0 (CA=0000001), first frame_start at cycle 32.
2. load value=16'h1234 in frame 0 -> frame 1:
   - digit0 slot: first 3 output cycles (1 latency + 2 guard) dark, then AN=1110, CA=1001100 for 6 cycles.
   - digit3 slot: AN=0111, CA=1001111.
3. load 16'hABCD while idx=1, then load 16'h00EF while idx=2 -> rest of the frame shows the prior value; next frame shows EF: digit0 CA=0111000, digit1 CA=0110000.
4. lz_blank=1, value=16'h0050 -> digits 3,2 never lit; digit1 CA=0100100; digit0 CA=0000001. value=16'h0000 -> only digit0 lit.
5. digit_en=4'b1010, dp_in=4'b0010 -> AN bits 0 and 2 never low; DP=0 only in lit cycles of digit1; DP=1 during digit3.
6. load coincident with the frame boundary, value=16'h9999 -> next frame shows CA=0000100 on all digits; with SEVSEG_DIM_EN and brightness=4, each lit digit is on exactly when phase is 0..3.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// ---------------------
// Time-multiplexed hex driver for a common-anode 7-segment bank of DIGITS
// digits. One digit is addressed per slot of DIV clock cycles. The first GUARD
// cycles of every slot are kept dark so the previous digit's segment pattern
// cannot ghost onto the next anode.
//
// The displayed value is double-buffered. A load goes to a pending buffer, and
// the pending buffer is promoted to the active buffer only at the last cycle of
// a frame, so a frame never shows a mix of two values.
//
// Optional build macro: SEVSEG_DIM_EN
//   Adds a brightness[3:0] input and a free-running 4-bit phase counter. A digit
//   is then lit only while phase < brightness.
//
// Parameters:
//   DIGITS : number of scanned digits (1..16)
//   DIV    : clock cycles per digit slot (>= 2)
//   GUARD  : dark cycles at the start of each slot (0 <= GUARD < DIV)
//
// Ports:
//   clk         : system clock
//   reset       : synchronous reset, active-high
//   load        : one-cycle strobe that captures value/dp_in into the pending buffer
//   value       : hex nibbles; nibble i drives digit i, and digit 0 is rightmost
//   dp_in       : decimal point request per digit (1 = lit), captured with value
//   digit_en    : live per-digit enable (0 = digit dark)
//   lz_blank    : live leading-zero blanking enable
//   brightness  : (SEVSEG_DIM_EN only) live duty control, 0 = dark, 15 = 15/16
//   CA          : segments a..g on CA[6]..CA[0], active-low
//   DP          : decimal point, active-low
//   AN          : digit anodes, active-low
//   frame_start : one-cycle pulse in the first cycle of each scan frame
module seven_seg_scan_driver #(
   parameter int DIGITS = 8,
   parameter int DIV    = 100000,
   parameter int GUARD  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_blank,
`ifdef SEVSEG_DIM_EN
   input  logic [3:0]            brightness,
`endif
   output logic [6:0]            CA,
   output logic                  DP,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_start
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

   // Hex-to-segment decode (active-low, a..g = bit 6..0).
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         4'hF:    seg = 7'b0111000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   act_val_q, act_val_d;
   logic [DIGITS-1:0]     act_dp_q, act_dp_d;
   logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [6:0]            ca_q, ca_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  fs_q, fs_d;
`ifdef SEVSEG_DIM_EN
   logic [3:0]            phase_q, phase_d;
`endif

   logic                  boundary_s;
   logic [3:0]            nib_s;
   logic                  sel_dp_s;
   logic                  sel_en_s;
   logic                  upper_nz_s;
   logic                  blank_s;
   logic                  lit_s;

   // Slot counter and digit index; the frame boundary is the last cycle of the last slot.
   always_comb begin
      boundary_s = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      cnt_d      = cnt_q + CW'(1);
      idx_d      = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end else begin
         idx_d = idx_q;
      end
`ifdef SEVSEG_DIM_EN
      phase_d = phase_q + 4'd1;
`endif
   end

   // Double buffer: a load coincident with the boundary bypasses the pending copy.
   always_comb begin
      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_vld_d = pend_vld_q;
      if (boundary_s) begin
         if (load) begin
            act_val_d = value;
            act_dp_d  = dp_in;
         end else if (pend_vld_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
         end else begin
            act_val_d = act_val_q;
            act_dp_d  = act_dp_q;
         end
         pend_vld_d = 1'b0;
      end else if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_in;
         pend_vld_d = 1'b1;
      end else begin
         pend_vld_d = pend_vld_q;
      end
   end

   // Select the current digit and decide whether it is lit this cycle.
   always_comb begin
      nib_s      = 4'h0;
      sel_dp_s   = 1'b0;
      sel_en_s   = 1'b0;
      upper_nz_s = 1'b0;
      // One-hot OR mux; upper_nz_s flags any nonzero nibble at or above idx.
      for (int i = 0; i < DIGITS; i++) begin
         nib_s      = nib_s | ((IW'(i) == idx_q) ? act_val_q[4*i +: 4] : 4'h0);
         sel_dp_s   = sel_dp_s | ((IW'(i) == idx_q) && act_dp_q[i]);
         sel_en_s   = sel_en_s | ((IW'(i) == idx_q) && digit_en[i]);
         upper_nz_s = upper_nz_s | ((IW'(i) >= idx_q) && (act_val_q[4*i +: 4] != 4'h0));
      end
      blank_s = lz_blank && (idx_q != '0) && !upper_nz_s;
      lit_s   = (cnt_q >= GUARD_C) && sel_en_s && !blank_s
`ifdef SEVSEG_DIM_EN
                && (phase_q < brightness)
`endif
                ;
   end

   // Next values of the registered pins.
   always_comb begin
      ca_d = lit_s ? seg_decode(nib_s) : 7'h7F;
      dp_d = lit_s ? ~sel_dp_s : 1'b1;
      fs_d = boundary_s;
      an_d = '1;
      for (int i = 0; i < DIGITS; i++) begin
         an_d[i] = ~(lit_s && (IW'(i) == idx_q));
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_vld_q <= 1'b0;
         ca_q       <= 7'h7F;
         dp_q       <= 1'b1;
         an_q       <= '1;
         fs_q       <= 1'b0;
`ifdef SEVSEG_DIM_EN
         phase_q    <= 4'd0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_vld_q <= pend_vld_d;
         ca_q       <= ca_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         fs_q       <= fs_d;
`ifdef SEVSEG_DIM_EN
         phase_q    <= phase_d;
`endif
      end
   end

   assign CA          = ca_q;
   assign DP          = dp_q;
   assign AN          = an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with DIGITS=4, DIV=8, GUARD=2.
// A cycle model pushes the expected pin values for each clock edge into a
// scoreboard queue. The entry is popped and compared on the following falling edge.
module tb_seven_seg_scan_driver;
   localparam int DIGITS = 4;
   localparam int DIV    = 8;
   localparam int GUARD  = 2;
   localparam int FRAME  = DIGITS * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        lz_blank;
   logic [6:0]  CA;
   logic        DP;
   logic [3:0]  AN;
   logic        frame_start;
`ifdef SEVSEG_DIM_EN
   logic [3:0]  brightness = 4'd15;
`endif

   always #5 clk = ~clk;

   seven_seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .value       (value),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .lz_blank    (lz_blank),
`ifdef SEVSEG_DIM_EN
      .brightness  (brightness),
`endif
      .CA          (CA),
      .DP          (DP),
      .AN          (AN),
      .frame_start (frame_start)
   );

   typedef struct packed {
      logic [6:0] ca;
      logic       dp;
      logic [3:0] an;
      logic       fs;
   } exp_t;

   logic [6:0] seg_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   // Model state: m_t counts non-reset edges since the last reset.
   int          m_t = 0;
   logic [15:0] m_act = 16'h0;
   logic [3:0]  m_actdp = 4'h0;
   logic [15:0] m_pend = 16'h0;
   logic [3:0]  m_pdp = 4'h0;
   logic        m_pv = 1'b0;
   int          edges = 0;
   int          first_fs = -1;
   int          an_low [4];
   int          dp_bad = 0;
   int          ph = 0;
`ifdef SEVSEG_DIM_EN
   int          dim_ph = 0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected pins after the next edge, based on the model state and the current inputs.
   function automatic exp_t model_out();
      exp_t e;
      int cnt;
      int idx;
      logic blank;
      logic lit;
      e = '{ca: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
      if (!reset) begin
         cnt   = m_t % DIV;
         idx   = (m_t / DIV) % DIGITS;
         blank = lz_blank && (idx != 0) && ((m_act >> (idx * 4)) == 16'h0);
         lit   = (cnt >= GUARD) && digit_en[idx] && !blank;
`ifdef SEVSEG_DIM_EN
         lit   = lit && (dim_ph < int'(brightness));
`endif
         if (lit) begin
            e.an[idx] = 1'b0;
            e.ca      = seg_tab[m_act[idx*4 +: 4]];
            e.dp      = ~m_actdp[idx];
         end
         e.fs = (cnt == DIV - 1) && (idx == DIGITS - 1);
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      sb_q.push_back(model_out());
      @(posedge clk);
      if (reset) begin
         m_t = 0; m_act = 16'h0; m_actdp = 4'h0; m_pv = 1'b0;
`ifdef SEVSEG_DIM_EN
         dim_ph = 0;
`endif
      end else begin
         if ((m_t % FRAME) == FRAME - 1) begin
            if (load) begin
               m_act = value; m_actdp = dp_in;
            end else if (m_pv) begin
               m_act = m_pend; m_actdp = m_pdp;
            end
            m_pv = 1'b0;
         end else if (load) begin
            m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
         end
         m_t++;
         edges++;
`ifdef SEVSEG_DIM_EN
         dim_ph = (dim_ph + 1) % 16;
`endif
      end
      @(negedge clk);
      e = sb_q.pop_front();
      chk("CA", {25'h0, CA}, {25'h0, e.ca});
      chk("DP", {31'h0, DP}, {31'h0, e.dp});
      chk("AN", {28'h0, AN}, {28'h0, e.an});
      chk("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
      chk("AN_onehot0", {31'h0, $countones(~AN) <= 1}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         if (!AN[i]) an_low[i]++;
      end
      if (!DP && AN != 4'b1101) dp_bad++;
      if (frame_start && first_fs < 0) first_fs = edges;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the model sits at the requested position within the frame.
   task automatic run_to(input int pos);
      int guard_cnt;
      guard_cnt = 0;
      while ((m_t % FRAME) != pos && guard_cnt < 4 * FRAME) begin
         step();
         guard_cnt++;
      end
      chk("run_to_bound", {31'h0, guard_cnt < 4 * FRAME}, 32'h1);
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      value = v; dp_in = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
      digit_en = 4'hF; lz_blank = 1'b0;
      for (int i = 0; i < 4; i++) an_low[i] = 0;

      // Reset held with load toggling: pins stay dark.
      for (int i = 0; i < 20; i++) begin
         load  = i[0];
         value = 16'($urandom);
         step();
      end
      load = 1'b0;
      reset = 1'b0;

      // Load 1234 in frame 0; frame 1 shows it.
      run(3);
      pulse_load(16'h1234, 4'h0);
      run_to(0);
      chk("first_frame_start", first_fs, 32);
      run(FRAME);

      // Two loads inside one frame; the last one wins at the boundary.
      run_to(9);
      pulse_load(16'hABCD, 4'h0);
      run_to(18);
      pulse_load(16'h00EF, 4'h0);
      run_to(0);
      run(FRAME);

      // Leading-zero blanking.
      lz_blank = 1'b1;
      pulse_load(16'h0050, 4'h0);
      run_to(0);
      run(FRAME);
      pulse_load(16'h0000, 4'h0);
      run_to(0);
      run(FRAME);
      lz_blank = 1'b0;

      // Per-digit enable and decimal point.
      digit_en = 4'b1010;
      pulse_load(16'h1234, 4'b0010);
      for (int i = 0; i < 4; i++) an_low[i] = 0;
      dp_bad = 0;
      run_to(0);
      run(FRAME);
      chk("an0_never_low", an_low[0], 0);
      chk("an2_never_low", an_low[2], 0);
      chk("dp_only_digit1", dp_bad, 0);
      chk("an1_lit_cycles", {31'h0, an_low[1] > 0}, 32'h1);
      digit_en = 4'hF;

      // Load coincident with the frame boundary commits at once.
      run_to(FRAME - 1);
      pulse_load(16'h9999, 4'h0);
      run(FRAME);

`ifdef SEVSEG_DIM_EN
      brightness = 4'd4;
      run(2 * FRAME);
      brightness = 4'd15;
`endif

      // Reset mid-operation drops a pending load.
      run_to(5);
      pulse_load(16'h5555, 4'hF);
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(2 * FRAME + 4);
      chk("sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
